// File: rtl/wb_stage_pkg.sv
// Shared defines for the writeback stage: data width, ROB id width and
// instruction type encodings.
package wb_stage_pkg;

  localparam int WORD_SIZE = 32;
  localparam int ROB_ID_W  = 7;

  localparam logic [1:0] INSTR_TYPE_ALU    = 2'd0;
  localparam logic [1:0] INSTR_TYPE_LOAD   = 2'd1;
  localparam logic [1:0] INSTR_TYPE_STORE  = 2'd2;
  localparam logic [1:0] INSTR_TYPE_BRANCH = 2'd3;

endpackage

// File: rtl/wb_mul_fifo.sv
// Circular queue that buffers multiplier completions until the single ROB
// write port is free.
module wb_mul_fifo
  import wb_stage_pkg::*;
#(
  parameter int WIDTH = 71,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       clear,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign full      = (r_count == CW'(DEPTH));
  assign empty     = (r_count == {CW{1'b0}});
  assign count     = r_count;
  assign rdata     = r_mem[r_rd_ptr];
  assign w_do_push = push && !full;
  assign w_do_pop  = pop && !empty;

  // Pointer and occupancy update; DEPTH is a power of two so pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      r_wr_ptr <= {AW{1'b0}};
      r_rd_ptr <= {AW{1'b0}};
      r_count  <= {CW{1'b0}};
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + {{(AW-1){1'b0}}, 1'b1};
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + {{(AW-1){1'b0}}, 1'b1};
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + {{(CW-1){1'b0}}, 1'b1};
        2'b01:   r_count <= r_count - {{(CW-1){1'b0}}, 1'b1};
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage array, written only on an accepted push.
  always_ff @(posedge clk) begin
    if (w_do_push && !clear && !reset) r_mem[r_wr_ptr] <= wdata;
  end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: arbitrates the M/WB register and queued multiplier results
// onto one registered ROB write port, M path first.
module wb_stage
  import wb_stage_pkg::*;
#(
  parameter int WORD_SIZE      = wb_stage_pkg::WORD_SIZE,
  parameter int MUL_FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  m_valid,
  input  logic [1:0]            m_instruction_type,
  input  logic [WORD_SIZE-1:0]  m_pc,
  input  logic                  m_exception,
  input  logic [WORD_SIZE-1:0]  m_virtual_addr_exception,
  input  logic [WORD_SIZE-1:0]  m_aluResult,
  input  logic [ROB_ID_W-1:0]   m_rob_id,
  input  logic                  mul_valid,
  input  logic [WORD_SIZE-1:0]  mul_result,
  input  logic [WORD_SIZE-1:0]  mul_pc,
  input  logic [ROB_ID_W-1:0]   mul_rob_id,
  output logic                  mul_ready,
  output logic                  rob_wr_en,
  output logic [ROB_ID_W-1:0]   rob_wr_id,
  output logic [WORD_SIZE-1:0]  rob_wr_value,
  output logic [WORD_SIZE-1:0]  rob_wr_pc,
  output logic                  rob_wr_exception,
  output logic [WORD_SIZE-1:0]  rob_wr_vaddr,
  output logic [1:0]            rob_wr_type
);

  localparam int EW = 2 * WORD_SIZE + ROB_ID_W;
  localparam int CW = $clog2(MUL_FIFO_DEPTH) + 1;

  logic                 w_push;
  logic                 w_pop;
  logic                 w_full;
  logic                 w_empty;
  logic [CW-1:0]        w_count;
  logic [EW-1:0]        w_head;
  logic [WORD_SIZE-1:0] w_head_value;
  logic [WORD_SIZE-1:0] w_head_pc;
  logic [ROB_ID_W-1:0]  w_head_id;

  // Readiness depends only on occupancy, so a same-cycle pop never frees a slot.
  assign mul_ready = !w_full;
  assign w_push    = mul_valid && mul_ready && !flush;
  assign w_pop     = !flush && !m_valid && !w_empty;
  assign {w_head_value, w_head_pc, w_head_id} = w_head;

  wb_mul_fifo #(
    .WIDTH (EW),
    .DEPTH (MUL_FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .clear (flush),
    .push  (w_push),
    .pop   (w_pop),
    .wdata ({mul_result, mul_pc, mul_rob_id}),
    .rdata (w_head),
    .full  (w_full),
    .empty (w_empty),
    .count (w_count)
  );

  // ROB write port register; data fields hold whenever no write is issued.
  always_ff @(posedge clk) begin
    if (reset) begin
      rob_wr_en        <= 1'b0;
      rob_wr_id        <= {ROB_ID_W{1'b0}};
      rob_wr_value     <= {WORD_SIZE{1'b0}};
      rob_wr_pc        <= {WORD_SIZE{1'b0}};
      rob_wr_exception <= 1'b0;
      rob_wr_vaddr     <= {WORD_SIZE{1'b0}};
      rob_wr_type      <= 2'b00;
    end else if (flush) begin
      rob_wr_en <= 1'b0;
    end else if (m_valid) begin
      rob_wr_en        <= 1'b1;
      rob_wr_id        <= m_rob_id;
      rob_wr_value     <= m_aluResult;
      rob_wr_pc        <= m_pc;
      rob_wr_exception <= m_exception;
      rob_wr_vaddr     <= m_virtual_addr_exception;
      rob_wr_type      <= m_instruction_type;
    end else if (w_pop) begin
      rob_wr_en        <= 1'b1;
      rob_wr_id        <= w_head_id;
      rob_wr_value     <= w_head_value;
      rob_wr_pc        <= w_head_pc;
      rob_wr_exception <= 1'b0;
      rob_wr_vaddr     <= {WORD_SIZE{1'b0}};
      rob_wr_type      <= INSTR_TYPE_ALU;
    end else begin
      rob_wr_en <= 1'b0;
    end
  end

endmodule
